// File: rtl/cpu_bus_responder.sv
// CPU-side bus responder: decodes RAM / PPU / PRG windows, serves reads with one
// cycle of latency, and runs the 256-byte OAM DMA that stalls the CPU via halt.
module cpu_bus_responder #(
  parameter logic [15:0] DMA_PAGE_REG = 16'h4014
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mem_addr,
  input  logic [7:0]  mem_data_out,
  input  logic        mem_write_en,
  input  logic        mem_read_en,
  output logic [7:0]  mem_data_in,
  output logic        halt,
  output logic [2:0]  ppu_reg,
  output logic [7:0]  ppu_wdata,
  output logic        ppu_we,
  output logic        ppu_re,
  input  logic [7:0]  ppu_rdata,
  output logic [14:0] prg_addr,
  input  logic [7:0]  prg_rdata,
  output logic [7:0]  oam_wdata,
  output logic        oam_we
);

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_PPU  = 2'd2,
    SRC_PRG  = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RD    = 2'd2,
    ST_WR    = 2'd3
  } dma_state_e;

  // The DMA engine cannot see PPU registers, so that window reads back as zero for it.
  function automatic src_e decode_src(input logic [15:0] addr, input logic ppu_visible);
    src_e src;
    if (addr == DMA_PAGE_REG) begin
      src = SRC_NONE;
    end else if (addr[15]) begin
      src = SRC_PRG;
    end else if (addr[15:13] == 3'b000) begin
      src = SRC_RAM;
    end else if (addr[15:13] == 3'b001) begin
      src = ppu_visible ? SRC_PPU : SRC_NONE;
    end else begin
      src = SRC_NONE;
    end
    return src;
  endfunction

  logic [7:0]  ram_r [0:2047];
  dma_state_e  state_r;
  logic [7:0]  page_r;
  logic [7:0]  idx_r;
  logic        halt_r;
  logic        oam_we_r;
  src_e        cpu_sel_r;
  src_e        dma_sel_r;
  logic [7:0]  cpu_ram_q_r;
  logic [7:0]  dma_ram_q_r;

  logic [15:0] dma_addr_s;
  src_e        cpu_src_s;
  src_e        dma_src_s;
  logic        wr_ok_s;
  logic        rd_ok_s;
  logic        trigger_s;

  assign dma_addr_s = {page_r, idx_r};
  assign cpu_src_s  = decode_src(mem_addr, 1'b1);
  assign dma_src_s  = decode_src(dma_addr_s, 1'b0);
  assign wr_ok_s    = mem_write_en && !halt_r;
  assign rd_ok_s    = mem_read_en && !mem_write_en && !halt_r;
  assign trigger_s  = wr_ok_s && (mem_addr == DMA_PAGE_REG);

  assign ppu_reg   = mem_addr[2:0];
  assign ppu_wdata = mem_data_out;
  assign ppu_we    = rst && wr_ok_s && (cpu_src_s == SRC_PPU);
  assign ppu_re    = rst && rd_ok_s && (cpu_src_s == SRC_PPU);
  assign prg_addr  = (state_r == ST_RD) ? dma_addr_s[14:0] : mem_addr[14:0];
  assign halt      = halt_r;
  assign oam_we    = oam_we_r;

  // Internal RAM array and its two read latches (CPU and DMA); contents survive reset.
  always_ff @(posedge clk) begin
    if (rst && wr_ok_s && (cpu_src_s == SRC_RAM)) begin
      ram_r[mem_addr[10:0]] <= mem_data_out;
    end
    if (rd_ok_s && (cpu_src_s == SRC_RAM)) begin
      cpu_ram_q_r <= ram_r[mem_addr[10:0]];
    end
    if (state_r == ST_RD) begin
      dma_ram_q_r <= ram_r[dma_addr_s[10:0]];
    end
  end

  // DMA sequencer plus the registered read-source selections.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      page_r    <= 8'h00;
      idx_r     <= 8'h00;
      halt_r    <= 1'b0;
      oam_we_r  <= 1'b0;
      cpu_sel_r <= SRC_NONE;
      dma_sel_r <= SRC_NONE;
    end else begin
      if (rd_ok_s) begin
        cpu_sel_r <= cpu_src_s;
      end
      case (state_r)
        ST_IDLE: begin
          oam_we_r <= 1'b0;
          if (trigger_s) begin
            state_r <= ST_ALIGN;
            page_r  <= mem_data_out;
            idx_r   <= 8'h00;
            halt_r  <= 1'b1;
          end
        end
        ST_ALIGN: begin
          state_r <= ST_RD;
        end
        ST_RD: begin
          state_r   <= ST_WR;
          dma_sel_r <= dma_src_s;
          oam_we_r  <= 1'b1;
        end
        ST_WR: begin
          oam_we_r <= 1'b0;
          idx_r    <= idx_r + 8'd1;
          if (idx_r == 8'hFF) begin
            state_r <= ST_IDLE;
            halt_r  <= 1'b0;
          end else begin
            state_r <= ST_RD;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          halt_r   <= 1'b0;
          oam_we_r <= 1'b0;
        end
      endcase
    end
  end

  // PRG data arrives one cycle after its address, so both muxes follow the live ROM input.
  always_comb begin
    mem_data_in = 8'h00;
    case (cpu_sel_r)
      SRC_RAM: mem_data_in = cpu_ram_q_r;
      SRC_PPU: mem_data_in = ppu_rdata;
      SRC_PRG: mem_data_in = prg_rdata;
      default: mem_data_in = 8'h00;
    endcase
  end

  // Byte pushed to OAM, selected by where the preceding DMA read landed.
  always_comb begin
    oam_wdata = 8'h00;
    case (dma_sel_r)
      SRC_RAM: oam_wdata = dma_ram_q_r;
      SRC_PRG: oam_wdata = prg_rdata;
      default: oam_wdata = 8'h00;
    endcase
  end

endmodule
